osc_stream_arbiter: RTL and testbench
=====================================

OSC_STREAM_ARBITER -- requirements
Module: osc_stream_arbiter

Interface
REQ-001 Parameter: PAT_W, 16, pattern/result width in bits; power of two, 4..32.
REQ-002 Parameter: LEN_W, $clog2(PAT_W), burst-length field width.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: req0 / req1  in  1 each  burst request from requester 0 / 1; held high until its done.
REQ-006 Port: len0 / len1  in  LEN_W each  burst length; 0 encodes PAT_W bits.
REQ-007 Port: pat0 / pat1  in  PAT_W each  input-bit pattern, applied LSB first.
REQ-008 Port: gnt  out  2  one-hot grant, held from load to done inclusive.
REQ-009 Port: busy  out  1  high in every non-IDLE state.
REQ-010 Port: done  out  1  one-cycle pulse; result, fstate and owner valid in that cycle and held until next load.
REQ-011 Port: result  out  PAT_W  captured core outputs; bit i = y in burst cycle i; unused upper bits 0.
REQ-012 Port: fstate  out  2  core state after last burst bit.
REQ-013 Port: owner  out  1  index of requester served by the last burst.

Function
REQ-014 Controller FSM SHALL have states IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: no request -> stay; any request -> LOAD in next cycle, winner latched.
REQ-016 Arbitration SHALL be round-robin: single request wins; simultaneous requests -> requester other than last owner wins; after reset requester 0 has priority.
REQ-017 LOAD (1 cycle): latch winner's pat and len, clear bit counter and result, force core to S0; gnt asserted.
REQ-018 RUN: one pattern bit per cycle into core input A; core output y captured into result[count]; exit to DONE after len cycles (PAT_W if len=0).
REQ-019 DONE (1 cycle): done=1, fstate = core state, return to IDLE.
REQ-020 Latency: request sampled at edge n -> gnt from cycle n+1, done at cycle n+2+L (L = effective length).
REQ-021 Core transitions (input A -> next state): S0: 0->S1, 1->S2; S1: 0->S0, 1->S3; S2: 0->S3, 1->S0; S3: 0->S2, 1->S1; Mealy output y = A in every state.
REQ-022 Requests SHALL be ignored while busy; pattern/length changes after LOAD have no effect.
REQ-023 Request withdrawn mid-burst: burst completes normally, done still pulses.
REQ-024 Same requester held high through DONE: re-arbitrated in IDLE; if other also requests it wins (no starvation).
REQ-025 Back-to-back: minimum one IDLE cycle between done and next LOAD.

Reset
REQ-026 On rst: FSM=IDLE, core=S0, gnt=0, busy=0, done=0, result=0, fstate=0, owner=0, priority pointer to requester 0.
REQ-027 rst mid-burst SHALL abort immediately with no done pulse; outputs take reset values asynchronously.

Configuration
REQ-028 Macro OSC_ARB_PARITY_EN defined: extra output port parity (1 bit) = XOR of result, valid with done, reset 0.
REQ-029 Macro OSC_ARB_PARITY_EN undefined: no parity port, no parity logic.

Structure
REQ-030 Shared package osc_pkg SHALL hold core state typedef (S0..S3, 2-bit encodings 0..3) and controller state typedef (IDLE, LOAD, RUN, DONE).
REQ-031 Core SHALL be a separate sub-module osc_core (clk, rst, clr, en, a, y, state); controller instantiates exactly one.

Verification
REQ-032 req0=1, pat0=0x000A, len0=4 -> done at cycle 6 after request, result=0x000A, fstate=0, owner=0.
REQ-033 req1=1, pat1=0x0003, len1=3 -> core path S0->S2->S0->S1, fstate=1, result=0x0003, owner=1.
REQ-034 req0 and req1 rise same cycle after reset -> requester 0 served first, then requester 1; gnt 01 then 10, one IDLE cycle between.
REQ-035 len0=0, pat0=0xFFFF -> 16 RUN cycles, result=0xFFFF, fstate=0 (pairs of 1s return to S0).
REQ-036 rst asserted at burst bit 2 -> busy, gnt, result clear immediately, no done; next request runs normally from S0.
REQ-037 With OSC_ARB_PARITY_EN, pat0=0x0007, len0=3 -> parity=1 with done.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared types for the oscillator stream arbiter: core and controller state encodings
// plus the core next-state function.
package osc_pkg;

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} core_state_e;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} ctrl_state_e;

  function automatic core_state_e core_next(input core_state_e cur, input logic a);
    core_state_e nxt;
    unique case (cur)
      S0:      nxt = a ? S2 : S1;
      S1:      nxt = a ? S3 : S0;
      S2:      nxt = a ? S0 : S3;
      default: nxt = a ? S1 : S2;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/osc_core.sv
// Four-state Mealy core: one input bit per enabled cycle, output mirrors the input.
module osc_core
  import osc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        a,
  output logic        y,
  output core_state_e state
);

  core_state_e state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else if (clr) begin
      state_q <= S0;
    end else if (en) begin
      state_q <= core_next(state_q, a);
    end
  end

  assign y     = a;
  assign state = state_q;

endmodule

// File: rtl/osc_stream_arbiter.sv
// Round-robin two-requester burst controller driving a single osc_core.
// Optional parity output enabled with the OSC_ARB_PARITY_EN macro.
module osc_stream_arbiter
  import osc_pkg::*;
#(
  parameter int unsigned PAT_W = 16,
  parameter int unsigned LEN_W = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [PAT_W-1:0] pat0,
  input  logic [PAT_W-1:0] pat1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] result,
  output logic [1:0]       fstate,
  output logic             owner
`ifdef OSC_ARB_PARITY_EN
  ,
  output logic             parity
`endif
);

  ctrl_state_e       state_q, state_d;
  logic              owner_q, prio_q, winner;
  logic [PAT_W-1:0]  pat_q, result_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [LEN_W:0]    eff_len;
  logic [1:0]        fstate_q;
  logic              last;
  logic              core_clr, core_en, core_a, core_y;
  core_state_e       core_state;

  // prio_q names the requester that wins a tie
  assign winner  = (req0 && req1) ? prio_q : req1;
  assign eff_len = (len_q == '0) ? (LEN_W + 1)'(PAT_W) : {1'b0, len_q};
  assign last    = ({1'b0, cnt_q} == eff_len - 1'b1);
  assign core_a  = pat_q[cnt_q];

  always_comb begin
    state_d  = state_q;
    core_clr = 1'b0;
    core_en  = 1'b0;
    unique case (state_q)
      IDLE: if (req0 || req1) state_d = LOAD;
      LOAD: begin
        core_clr = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        core_en = 1'b1;
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      pat_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      fstate_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (state_d == LOAD) begin
            owner_q <= winner;
            prio_q  <= ~winner;
          end
        end
        LOAD: begin
          pat_q    <= owner_q ? pat1 : pat0;
          len_q    <= owner_q ? len1 : len0;
          cnt_q    <= '0;
          result_q <= '0;
        end
        RUN: begin
          result_q[cnt_q] <= core_y;
          cnt_q           <= cnt_q + 1'b1;
          // Capture the post-update state so fstate stays valid after the next LOAD clears the core
          if (last) fstate_q <= core_next(core_state, core_a);
        end
        default: ;
      endcase
    end
  end

  osc_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (core_clr),
    .en    (core_en),
    .a     (core_a),
    .y     (core_y),
    .state (core_state)
  );

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign gnt    = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign result = result_q;
  assign fstate = fstate_q;
  assign owner  = owner_q;

`ifdef OSC_ARB_PARITY_EN
  assign parity = ^result_q;
`endif

endmodule

// File: tb/tb_osc_stream_arbiter.sv
// Directed self-checking bench for osc_stream_arbiter with hand-computed expectations.
module tb_osc_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  len0, len1;
  logic [15:0] pat0, pat1;
  logic [1:0]  gnt;
  logic        busy, done;
  logic [15:0] result;
  logic [1:0]  fstate;
  logic        owner;
`ifdef OSC_ARB_PARITY_EN
  logic        parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  osc_stream_arbiter #(.PAT_W(16), .LEN_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .len0   (len0),
    .len1   (len1),
    .pat0   (pat0),
    .pat1   (pat1),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .result (result),
    .fstate (fstate),
    .owner  (owner)
`ifdef OSC_ARB_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done or the cycle budget runs out; edges counts clock edges since the request
  task automatic wait_done(inout int edges);
    while (done !== 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0; len0 = 0; len1 = 0; pat0 = 0; pat1 = 0;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", gnt); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL rst_result: got %h want 0000", result); end
    n_cmp++; if (fstate !== 2'd0) begin n_err++; $display("FAIL rst_fstate: got %0d want 0", fstate); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL rst_owner: got %b want 0", owner); end
`ifdef OSC_ARB_PARITY_EN
    n_cmp++; if (parity !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b want 0", parity); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_req0();
    int e;
    req0 = 1'b1; pat0 = 16'h000A; len0 = 4'd4;
    step(); e = 1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL r0_gnt: got %b want 01", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL r0_busy: got %b want 1", busy); end
    wait_done(e);
    n_cmp++; if (e !== 6) begin n_err++; $display("FAIL r0_latency: got %0d want 6", e); end
    n_cmp++; if (result !== 16'h000A) begin n_err++; $display("FAIL r0_result: got %h want 000a", result); end
    n_cmp++; if (fstate !== 2'd0) begin n_err++; $display("FAIL r0_fstate: got %0d want 0", fstate); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL r0_owner: got %b want 0", owner); end
    req0 = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL r0_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL r0_idle: got %b want 0", busy); end
    n_cmp++; if (result !== 16'h000A) begin n_err++; $display("FAIL r0_hold: got %h want 000a", result); end
  endtask

  task automatic test_req1();
    int e;
    req1 = 1'b1; pat1 = 16'h0003; len1 = 4'd3;
    step(); e = 1;
    step(); e = 2;
    // Changes after LOAD must not disturb the burst
    pat1 = 16'hFFFC; len1 = 4'd1;
    wait_done(e);
    n_cmp++; if (e !== 5) begin n_err++; $display("FAIL r1_latency: got %0d want 5", e); end
    n_cmp++; if (result !== 16'h0003) begin n_err++; $display("FAIL r1_result: got %h want 0003", result); end
    n_cmp++; if (fstate !== 2'd1) begin n_err++; $display("FAIL r1_fstate: got %0d want 1", fstate); end
    n_cmp++; if (owner !== 1'b1) begin n_err++; $display("FAIL r1_owner: got %b want 1", owner); end
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL r1_gnt: got %b want 10", gnt); end
    req1 = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int e;
    rst = 1'b1; step(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    pat0 = 16'h0001; len0 = 4'd1; pat1 = 16'h0002; len1 = 4'd2;
    step(); e = 1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rr_first_gnt: got %b want 01", gnt); end
    wait_done(e);
    n_cmp++; if (e !== 3) begin n_err++; $display("FAIL rr_first_lat: got %0d want 3", e); end
    n_cmp++; if (result !== 16'h0001) begin n_err++; $display("FAIL rr_first_result: got %h want 0001", result); end
    n_cmp++; if (fstate !== 2'd2) begin n_err++; $display("FAIL rr_first_fstate: got %0d want 2", fstate); end
    req0 = 1'b0;
    step();
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rr_idle_gnt: got %b want 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_busy: got %b want 0", busy); end
    step(); e = 1;
    n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL rr_second_gnt: got %b want 10", gnt); end
    wait_done(e);
    n_cmp++; if (e !== 4) begin n_err++; $display("FAIL rr_second_lat: got %0d want 4", e); end
    n_cmp++; if (result !== 16'h0002) begin n_err++; $display("FAIL rr_second_result: got %h want 0002", result); end
    n_cmp++; if (fstate !== 2'd3) begin n_err++; $display("FAIL rr_second_fstate: got %0d want 3", fstate); end
    n_cmp++; if (owner !== 1'b1) begin n_err++; $display("FAIL rr_second_owner: got %b want 1", owner); end
    // req1 stays high through DONE; req0 now contends and must win
    req0 = 1'b1;
    step();
    step(); e = 1;
    n_cmp++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rr_fair_gnt: got %b want 01", gnt); end
    // Withdraw both mid-burst; the burst still completes
    req0 = 1'b0; req1 = 1'b0;
    wait_done(e);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rr_withdraw_done: got %b want 1", done); end
    n_cmp++; if (owner !== 1'b0) begin n_err++; $display("FAIL rr_withdraw_owner: got %b want 0", owner); end
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_withdraw_idle: got %b want 0", busy); end
  endtask

  task automatic test_full_len();
    int e;
    req0 = 1'b1; pat0 = 16'hFFFF; len0 = 4'd0;
    step(); e = 1;
    wait_done(e);
    n_cmp++; if (e !== 18) begin n_err++; $display("FAIL full_latency: got %0d want 18", e); end
    n_cmp++; if (result !== 16'hFFFF) begin n_err++; $display("FAIL full_result: got %h want ffff", result); end
    n_cmp++; if (fstate !== 2'd0) begin n_err++; $display("FAIL full_fstate: got %0d want 0", fstate); end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int e;
    req0 = 1'b1; pat0 = 16'h0005; len0 = 4'd8;
    step(); step(); step(); step();
    n_cmp++; if (result !== 16'h0001) begin n_err++; $display("FAIL mid_pre_result: got %h want 0001", result); end
    #1 rst = 1'b1;
    req0 = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL mid_gnt: got %b want 00", gnt); end
    n_cmp++; if (result !== 16'h0) begin n_err++; $display("FAIL mid_result: got %h want 0000", result); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %b want 0", done); end
    req0 = 1'b1; pat0 = 16'h0003; len0 = 4'd3;
    step(); e = 1;
    wait_done(e);
    n_cmp++; if (e !== 5) begin n_err++; $display("FAIL mid_rerun_lat: got %0d want 5", e); end
    n_cmp++; if (result !== 16'h0003) begin n_err++; $display("FAIL mid_rerun_result: got %h want 0003", result); end
    n_cmp++; if (fstate !== 2'd1) begin n_err++; $display("FAIL mid_rerun_fstate: got %0d want 1", fstate); end
    req0 = 1'b0;
    step();
  endtask

`ifdef OSC_ARB_PARITY_EN
  task automatic test_parity();
    int e;
    req0 = 1'b1; pat0 = 16'h0007; len0 = 4'd3;
    step(); e = 1;
    wait_done(e);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL par_done: got %b want 1", done); end
    n_cmp++; if (parity !== 1'b1) begin n_err++; $display("FAIL par_value: got %b want 1", parity); end
    req0 = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_req0();
    test_req1();
    test_round_robin();
    test_full_len();
    test_reset_mid();
`ifdef OSC_ARB_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
